// File: rtl/onchip_ram_pipelined.sv
// Single-port on-chip RAM with byte enables, a 1- or 2-cycle read pipeline,
// optional zero-fill after reset and a sticky out-of-range flag.
module onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int DEPTH          = 20480,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    range_error
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
  localparam logic [MAW-1:0]      LAST_W  = MAW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t INIT_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic                  r_active;
  state_t                r_state;
  state_t                w_state_next;
  logic [MAW-1:0]        r_clr_cnt;
  logic [MAW-1:0]        w_clr_cnt_next;
  logic                  w_clr_we;
  logic                  w_req;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_in_range;
  logic                  w_mem_we;
  logic [MAW-1:0]        w_waddr;
  logic [MAW-1:0]        w_raddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [NB-1:0]         w_wbe;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_ram_q;
  logic                  r_s1_valid;
  logic                  r_s1_inrng;
  logic [DATA_WIDTH-1:0] w_s1_word;
  logic                  r_range_err;

  // Release synchroniser: logic starts acting on the second edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_active <= 1'b0;
    else          r_active <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= INIT_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_clr_we       = 1'b0;
    if (r_active && clken) begin
      case (r_state)
        ST_CLEAR: begin
          w_clr_we       = 1'b1;
          w_clr_cnt_next = r_clr_cnt + MAW'(1);
          if (r_clr_cnt == LAST_W) begin
            w_state_next   = ST_RUN;
            w_clr_cnt_next = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign waitrequest = ~r_active | (r_state != ST_RUN) | ~clken;
  assign w_req       = chipselect & (read | write) & ~waitrequest;
  assign w_wr_acc    = w_req & write;
  assign w_rd_acc    = w_req & read & ~write;
  assign w_in_range  = ({1'b0, address} < DEPTH_W);

  // Clearing and host writes share the one write port; they never overlap.
  assign w_mem_we = w_clr_we | (w_wr_acc & w_in_range);
  assign w_waddr  = w_clr_we ? r_clr_cnt : address[MAW-1:0];
  assign w_wdata  = w_clr_we ? '0 : writedata;
  assign w_wbe    = w_clr_we ? '1 : byteenable;
  assign w_raddr  = w_in_range ? address[MAW-1:0] : '0;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (w_mem_we && w_wbe[b]) r_mem[w_waddr][b*8 +: 8] <= w_wdata[b*8 +: 8];
    end
    if (w_rd_acc) r_ram_q <= r_mem[w_raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_inrng  <= 1'b0;
      r_range_err <= 1'b0;
    end else if (clken) begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_inrng <= w_in_range;
      if (w_req && !w_in_range) r_range_err <= 1'b1;
    end
  end

  assign range_error = r_range_err;
  assign w_s1_word   = r_s1_inrng ? r_ram_q : '0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s2_valid;
      logic [DATA_WIDTH-1:0] r_s2_data;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_s2_valid <= 1'b0;
          r_s2_data  <= '0;
        end else if (clken) begin
          r_s2_valid <= r_s1_valid;
          r_s2_data  <= w_s1_word;
        end
      end
      assign readdatavalid = r_s2_valid;
      assign readdata      = r_s2_valid ? r_s2_data : '0;
    end else begin : g_lat1
      assign readdatavalid = r_s1_valid;
      assign readdata      = r_s1_valid ? w_s1_word : '0;
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_pipelined.sv
// Drives a latency-1 and a latency-2 instance with the same directed vectors;
// per-instance monitors pop expected (data, due cycle) entries on readdatavalid.
module tb_onchip_ram_pipelined;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clken, chipselect, read, write;
  logic [AW-1:0] address;
  logic [3:0]    byteenable;
  logic [DW-1:0] writedata;
  logic          wr_a, rdv_a, re_a, wr_b, rdv_b, re_b;
  logic [DW-1:0] rd_a, rd_b;

  onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP),
                         .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
    .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(wr_a),
    .readdata(rd_a), .readdatavalid(rdv_a), .range_error(re_a));

  onchip_ram_pipelined #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP),
                         .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
    .chipselect(chipselect), .read(read), .write(write),
    .byteenable(byteenable), .writedata(writedata), .waitrequest(wr_b),
    .readdata(rd_b), .readdatavalid(rdv_b), .range_error(re_b));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   en_cyc   = 0;
  bit   last_en  = 1'b0;
  bit   mon_en   = 1'b0;
  int   compares = 0;
  int   errors   = 0;

  // Enabled-cycle counter; a response is due a fixed number of these after issue.
  always @(posedge clk) begin
    last_en = clken;
    if (clken) en_cyc++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compares++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    if (last_en && rdv_a) begin
      compares++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL lat1_spurious: got readdatavalid with %h, want no response", rd_a);
      end else begin
        e_a = q_a.pop_front();
        $display("lat1 read response data=%h cycle=%0d", rd_a, en_cyc);
        if (rd_a !== e_a.data || en_cyc != e_a.due) begin
          errors++;
          $display("FAIL lat1_read: got %h at cycle %0d, want %h at cycle %0d",
                   rd_a, en_cyc, e_a.data, e_a.due);
        end
      end
    end
    if (!rdv_a) check("lat1_rdata_idle", rd_a, 32'h0);
  end

  always @(negedge clk) if (mon_en) begin
    if (last_en && rdv_b) begin
      compares++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL lat2_spurious: got readdatavalid with %h, want no response", rd_b);
      end else begin
        e_b = q_b.pop_front();
        $display("lat2 read response data=%h cycle=%0d", rd_b, en_cyc);
        if (rd_b !== e_b.data || en_cyc != e_b.due) begin
          errors++;
          $display("FAIL lat2_read: got %h at cycle %0d, want %h at cycle %0d",
                   rd_b, en_cyc, e_b.data, e_b.due);
        end
      end
    end
    if (!rdv_b) check("lat2_rdata_idle", rd_b, 32'h0);
  end

  task automatic idle();
    chipselect = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'h0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    $display("write addr=%0d data=%h be=%b", a, d, be);
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    q_a.push_back('{d, en_cyc + 1});
    q_b.push_back('{d, en_cyc + 2});
    @(negedge clk);
    idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdv1"}, 32'(rdv_a), 32'h0);
    check({tag, "_rdv2"}, 32'(rdv_b), 32'h0);
    check({tag, "_rdata1"}, rd_a, 32'h0);
    check({tag, "_rdata2"}, rd_b, 32'h0);
    check({tag, "_rerr1"}, 32'(re_a), 32'h0);
    check({tag, "_rerr2"}, 32'(re_b), 32'h0);
    check({tag, "_wait1"}, 32'(wr_a), 32'h1);
    check({tag, "_wait2"}, 32'(wr_b), 32'h1);
  endtask

  task automatic count_clear(input string tag);
    int ca = 0;
    int cb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (wr_a) ca++;
      if (wr_b) cb++;
    end
    check({tag, "_lat1"}, 32'(ca), 32'd16);
    check({tag, "_lat2"}, 32'(cb), 32'd16);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; idle();
    address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    mon_en  = 1'b1;
    reset_n = 1'b1;
    count_clear("clear_cycles");

    for (int i = 0; i < DP; i++) rd(AW'(i), 32'h0);
    repeat (3) @(negedge clk);

    wr(5'd3, 32'hA5A5A5A5, 4'b1111);
    wr(5'd3, 32'h000000FF, 4'b0001);
    rd(5'd3, 32'hA5A5A5FF);
    wr(5'd3, 32'hFFFFFFFF, 4'b0000);
    rd(5'd3, 32'hA5A5A5FF);
    wr(5'd4, 32'h11223344, 4'b1111);
    wr(5'd4, 32'hAABBCCDD, 4'b0110);
    rd(5'd4, 32'h11BBCC44);
    repeat (3) @(negedge clk);

    wr(5'd0, 32'h00000100, 4'b1111);
    wr(5'd1, 32'h00000101, 4'b1111);
    wr(5'd2, 32'h00000102, 4'b1111);
    rd(5'd0, 32'h00000100);
    rd(5'd1, 32'h00000101);
    clken = 1'b0;
    @(negedge clk);
    check("wait_clken_low", 32'(wr_a), 32'h1);
    @(negedge clk);
    clken = 1'b1;
    rd(5'd2, 32'h00000102);
    repeat (3) @(negedge clk);

    wr(5'd15, 32'hCAFEF00D, 4'b1111);
    check("rerr_before", 32'(re_a), 32'h0);
    wr(5'd16, 32'hDEADBEEF, 4'b1111);
    check("rerr_set_lat1", 32'(re_a), 32'h1);
    check("rerr_set_lat2", 32'(re_b), 32'h1);
    rd(5'd16, 32'h0);
    rd(5'd15, 32'hCAFEF00D);
    rd(5'd0, 32'h00000100);
    repeat (4) @(negedge clk);
    check("rerr_held", 32'(re_b), 32'h1);

    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 5'd5; writedata = 32'h12345678; byteenable = 4'b1111;
    $display("read+write addr=5 data=12345678");
    @(negedge clk);
    idle();
    rd(5'd5, 32'h12345678);
    repeat (3) @(negedge clk);

    // Read left in flight (still in stage 1 of the latency-2 instance) when reset hits.
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 5'd2;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    check_reset_outputs("reset_inflight");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("clear_word7_wait", 32'(wr_a), 32'h1);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_midclear");
    reset_n = 1'b1;
    count_clear("clear_restart");
    rd(5'd3, 32'h0);
    rd(5'd15, 32'h0);
    rd(5'd5, 32'h0);
    repeat (4) @(negedge clk);

    check("lat1_all_responses", 32'(q_a.size()), 32'h0);
    check("lat2_all_responses", 32'(q_b.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", compares, errors);
    $finish;
  end
endmodule

// File: doc/onchip_ram_pipelined.md
ONCHIP_RAM_PIPELINED -- requirements
Module: onchip_ram_pipelined

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, word width in bits; a multiple of 8, range 8..128.
REQ-002 SHALL have parameter ADDR_WIDTH, 15, word address width.
REQ-003 SHALL have parameter DEPTH, 20480, number of words; 2 <= DEPTH <= 2^ADDR_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, 1, cycles from an accepted read to readdatavalid; legal values 1 or 2.
REQ-005 SHALL have parameter CLEAR_ON_RESET, 1, zero-fill memory after reset when 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port clken, input, 1, clock enable; low freezes all internal state.
REQ-009 SHALL have port address, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port chipselect, input, 1, qualifies read/write.
REQ-011 SHALL have port read, input, 1, read request.
REQ-012 SHALL have port write, input, 1, write request.
REQ-013 SHALL have port byteenable, input, DATA_WIDTH/8, per-byte write enable.
REQ-014 SHALL have port writedata, input, DATA_WIDTH, write data.
REQ-015 SHALL have port waitrequest, output, 1, request not accepted this cycle.
REQ-016 SHALL have port readdata, output, DATA_WIDTH, read data.
REQ-017 SHALL have port readdatavalid, output, 1, readdata valid this cycle.
REQ-018 SHALL have port range_error, output, 1, sticky flag for an out-of-range access.

Function
REQ-019 SHALL implement a FSM with states CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET=1, else RUN.
REQ-020 In CLEAR: one word per enabled cycle, counting up from 0, all bytes written 0; waitrequest=1; after word DEPTH-1 is written, the next state is RUN.
REQ-021 In RUN: waitrequest = ~clken; a request is accepted when chipselect & (read|write) & ~waitrequest.
REQ-022 read and write asserted together: the write SHALL take priority, the read is dropped, and no readdatavalid is generated.
REQ-023 Accepted write: write only the bytes whose byteenable bit is 1; byteenable=0 is a legal no-op.
REQ-024 Accepted read at cycle N: readdatavalid=1 with the data at cycle N+READ_LATENCY, counted in clken-high cycles only; back-to-back reads at one per cycle.
REQ-025 Read and write to the same address in the same cycle are not possible (REQ-022); a read accepted in the cycle after a write returns the newly written data.
REQ-026 Address >= DEPTH: write suppressed; read returns all-zero data with normal readdatavalid timing; range_error is set and held until reset.
REQ-027 clken=0: no memory write, no clear-counter advance, the read pipeline holds, and readdatavalid/readdata hold their values.
REQ-028 readdata SHALL be 0 whenever readdatavalid=0.
REQ-029 Memory contents are not reset by reset_n (only by CLEAR); with CLEAR_ON_RESET=0, contents are undefined.

Reset
REQ-030 While reset_n=0: readdatavalid=0, readdata=0, range_error=0, waitrequest=1, clear counter=0; the read pipeline is flushed.
REQ-031 reset_n asserted mid-CLEAR or with reads in flight: the in-flight reads are discarded, with no readdatavalid after release; on release, clearing restarts from word 0.
REQ-032 reset_n deassertion is synchronised internally so that the first RUN/CLEAR cycle is the second clk edge after release.

Verification
REQ-033 DEPTH=16, CLEAR_ON_RESET=1: release reset -> waitrequest=1 for 16 enabled cycles, then 0; reading addr 0..15 returns 0x00000000.
REQ-034 Write 0xA5A5A5A5 to addr 3 with be=4'b1111, then 0x000000FF with be=4'b0001, then read addr 3 -> 0xA5A5A5FF at N+READ_LATENCY; repeat with READ_LATENCY=2.
REQ-035 Back-to-back reads of addr 0,1,2 -> three consecutive readdatavalid pulses in order; clken low for 2 cycles in the middle -> the pulses stretch by exactly 2 cycles with no loss.
REQ-036 Write then read addr 16 with DEPTH=16 -> readdata 0, readdatavalid on time, range_error=1 and held; addr 15 is unchanged.
REQ-037 Assert reset_n at clear word 7, with one read in flight -> no readdatavalid; after release, CLEAR restarts at 0 and runs the full 16 cycles.
REQ-038 read=write=1 at addr 5 with data 0x12345678 -> memory updated, no readdatavalid; a subsequent read returns 0x12345678.
